// File: rtl/pll_pkg.sv
// Shared definitions for the CC_PLL lock supervisor: state encoding,
// default timing for a 10 MHz board reference, and a small helper used
// to size the shared timer.
package pll_pkg;

  // Supervisor states, 3-bit encoding.
  typedef enum logic [2:0] {
    INIT      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Defaults for a 10 MHz reference clock.
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_RST_HOLD      = 16;
  localparam int DEF_LOCK_TIMEOUT  = 100000;  // 10 ms
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_LOSS_W        = 8;

  // Largest of three durations; the shared timer must reach all of them.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level. Flops clear to 0
// on the synchronous reset. Also meant for PLL-domain consumers that need
// to resynchronise sys_reset into their own clock.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// CC_PLL bring-up / recovery sequencer. Pulses the sticky steady-lock reset,
// waits for lock, qualifies it over a run of consecutive locked cycles and
// then releases the PLL-domain system reset. Loss of lock re-sequences;
// repeated lock timeouts park the block in FAULT until reset.
// Clocked from the free-running board reference, never from the PLL output.
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RST_HOLD      = DEF_RST_HOLD,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int LOSS_W        = DEF_LOSS_W
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              pll_locked,
  output logic              pll_stdy_rst,
  output logic              sys_reset,
  output logic              ready,
  output logic              fault,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int TIMER_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_HOLD)) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  // Terminal timer values: the transition fires on the last cycle of a phase.
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
  logic [LOSS_W-1:0]   loss_d;
  logic                locked_s;
  logic                stdy_d, sys_reset_d, ready_d, fault_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (pll_locked),
    .q        (locked_s)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  // Next-state, counter updates and output decode from the next state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = lock_loss_count;

    case (state_q)
      INIT: begin
        if (timer_q == HOLD_LAST) state_d = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? FAULT : INIT;
        end
      end

      STABLE: begin
        // A drop on the terminal cycle still wins over the release.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end

      RUN: begin
        if (!locked_s) begin
          state_d = INIT;
          loss_d  = (&lock_loss_count) ? lock_loss_count
                                       : lock_loss_count + LOSS_W'(1);
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = INIT;
      end
    endcase

    // Shared timer: restarts on any state change, idle where unused.
    if (state_d != state_q || state_q == RUN || state_q == FAULT) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    stdy_d      = (state_d == INIT);
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q         <= INIT;
      timer_q         <= '0;
      retry_q         <= '0;
      lock_loss_count <= '0;
      pll_stdy_rst    <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      retry_q         <= retry_d;
      lock_loss_count <= loss_d;
      pll_stdy_rst    <= stdy_d;
      sys_reset       <= sys_reset_d;
      ready           <= ready_d;
      fault           <= fault_d;
    end
  end

endmodule
